// File: rtl/ccg_eval_arbiter.sv
// ccg_eval_arbiter: round-robin shared f1/f8 evaluator with one registered result stage; CCG_EVAL_STATS_EN adds eval_count
module ccg_eval_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ-1:0] req_x2,
  input  logic [NREQ-1:0] req_x12,
  input  logic [NREQ-1:0] req_x21,
  input  logic [NREQ-1:0] req_x14,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_f1,
  output logic            rsp_f8,
  output logic            busy
`ifdef CCG_EVAL_STATS_EN
  , output logic [CNT_W-1:0] eval_count
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, gid;
  logic found, can_accept, transfer;
  int idx;
  always_comb begin
    gid = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        gid = ID_W'(idx);
      end
    end
  end
  assign can_accept = (state == EMPTY) || rsp_ready;
  // no grant while reset is held, so nothing transfers into a cleared stage
  assign req_ready = (can_accept && found && !rst) ? (NREQ'(1) << gid) : '0;
  assign transfer = |req_ready;
  assign rsp_valid = state == FULL;
  assign busy = rsp_valid || (|req_valid);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EMPTY;
      rsp_id <= '0;
      rsp_f1 <= 1'b0;
      rsp_f8 <= 1'b0;
      rr_ptr <= ID_W'(NREQ - 1);
`ifdef CCG_EVAL_STATS_EN
      eval_count <= '0;
`endif
    end else if (transfer) begin
      state <= FULL;
      rsp_id <= gid;
      rsp_f1 <= req_x21[gid] ^ (req_x2[gid] & req_x12[gid]);
      rsp_f8 <= req_x14[gid];
      rr_ptr <= gid;
`ifdef CCG_EVAL_STATS_EN
      eval_count <= eval_count + 1'b1;
`endif
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
endmodule
